// File: rtl/cache_arbiter.sv
// cache_arbiter: I/D line arbiter and 4-beat burst adaptor onto the single memory port.
// Define CACHE_ARB_RR_EN for round-robin I/D arbitration; otherwise the D-cache always wins.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              beat_q, beat_d;
    logic [NBEATS-1:0][BEAT_W-1:0] line_q, line_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          own_d_q, own_d_d;
    logic                          d_req, d_first;
    logic                          unused_addr_bits;

    assign d_req            = d_read | d_write;
    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

`ifdef CACHE_ARB_RR_EN
    logic last_d_q, last_d_d;
    // On contention the side that did not get the previous grant goes first.
    assign d_first = ~last_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_d_q <= 1'b0;
        else        last_d_q <= last_d_d;
    end
`else
    assign d_first = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            own_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            own_d_q <= own_d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        addr_d  = addr_q;
        own_d_d = own_d_q;
`ifdef CACHE_ARB_RR_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req && (!i_read || d_first)) begin
                    state_d = d_write ? D_WR : D_RD;
                    addr_d  = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    own_d_d = 1'b1;
                    if (d_write) line_d = d_wdata;
`ifdef CACHE_ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_read) begin
                    state_d = I_RD;
                    addr_d  = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    own_d_d = 1'b0;
`ifdef CACHE_ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            I_RD, D_RD: begin
                if (pmem_resp) begin
                    line_d[beat_q] = pmem_rdata;
                    beat_d         = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = DONE;
                end
            end
            D_WR: begin
                if (pmem_resp) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                beat_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode registered state only, so no request input reaches pmem_* combinationally.
    always_comb begin
        pmem_read  = (state_q == I_RD) || (state_q == D_RD);
        pmem_write = (state_q == D_WR);
        pmem_addr  = addr_q;
        pmem_wdata = (state_q == D_WR) ? line_q[beat_q] : '0;
        i_resp     = (state_q == DONE) && !own_d_q;
        d_resp     = (state_q == DONE) &&  own_d_q;
        i_rdata    = line_q;
        d_rdata    = line_q;
    end

`ifndef SYNTHESIS
    a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
        else $error("cache_arbiter: d_read and d_write asserted together");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed vector table, multi-cycle corner sequences and random
// transactions checked against a line/latency model of the arbiter.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] i_rdata, d_rdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [BW-1:0] pmem_wdata;
    logic [BW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    // Memory model: accepts one beat every `gap` command cycles, captures writes, serves rd_beats.
    int            gap   = 1;
    int            gcnt  = 0;
    int            mbeat = 0;
    logic [BW-1:0] rd_beats [4];
    logic [BW-1:0] wr_seen  [4];
    logic [AW-1:0] seen_addr;
    logic [1:0]    seen_cmd;

    always @(negedge clk) begin
        if (rst_n && (pmem_read || pmem_write)) begin
            gcnt++;
            if (gcnt >= gap) begin
                gcnt       = 0;
                pmem_resp  = 1'b1;
                pmem_rdata = rd_beats[mbeat];
                if (pmem_write) wr_seen[mbeat] = pmem_wdata;
                seen_addr  = pmem_addr;
                seen_cmd   = {pmem_write, pmem_read};
                mbeat      = (mbeat + 1) % 4;
            end else begin
                pmem_resp = 1'b0;
            end
        end else begin
            gcnt      = 0;
            mbeat     = 0;
            pmem_resp = 1'b0;
        end
    end

    typedef struct {
        int            kind;      // 0 I read, 1 D read, 2 D write
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            gap;
        bit            perturb;   // scramble D inputs mid-burst
        logic [LW-1:0] beats;     // memory contents {b3,b2,b1,b0}
        logic [AW-1:0] exp_addr;
        int            exp_lat;   // negedges from request to resp
        logic [LW-1:0] exp_line;  // returned line, or write beats {b3,b2,b1,b0}
    } vec_t;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input int kind, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                           input int g, input bit perturb,
                           output int lat, output int who, output logic [LW-1:0] rd);
        gap = g; lat = 0; who = -1; rd = '0;
        for (int b = 0; b < 4; b++) wr_seen[b] = '0;
        seen_addr = '0; seen_cmd = '0;
        case (kind)
            0:       begin i_addr = a; i_read = 1'b1; end
            1:       begin d_addr = a; d_read = 1'b1; end
            default: begin d_addr = a; d_wdata = wd; d_write = 1'b1; end
        endcase
        while (who < 0 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (perturb && lat == 2) begin d_addr = ~a; d_wdata = ~wd; end
            if (i_resp) who = 0;
            else if (d_resp) who = 1;
        end
        rd = (who == 0) ? i_rdata : d_rdata;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        chk("resp_single_pulse", LW'({i_resp, d_resp}), LW'(2'b00));
    endtask

    task automatic apply(input string tag, input vec_t v);
        int            lat, who;
        logic [LW-1:0] rd, seen;
        for (int b = 0; b < 4; b++) rd_beats[b] = v.beats[b*BW +: BW];
        run_txn(v.kind, v.addr, v.wdata, v.gap, v.perturb, lat, who, rd);
        chk({tag, "_owner"}, LW'(who), LW'((v.kind == 0) ? 0 : 1));
        chk({tag, "_latency"}, LW'(lat), LW'(v.exp_lat));
        chk({tag, "_pmem_addr"}, LW'(seen_addr), LW'(v.exp_addr));
        chk({tag, "_cmd"}, LW'(seen_cmd), LW'((v.kind == 2) ? 2'b10 : 2'b01));
        seen = (v.kind == 2) ? {wr_seen[3], wr_seen[2], wr_seen[1], wr_seen[0]} : rd;
        chk({tag, "_line"}, seen, v.exp_line);
    endtask

    vec_t vecs [5];
    int   exp_order [4];

    initial begin
        int            w, who, lat;
        logic [LW-1:0] rd;
        bit            resp_seen;
        vec_t          r;

        vecs[0] = '{0, 32'h0000_1044, 256'h0, 1, 1'b0,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                    32'h0000_1040, 5,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
        vecs[1] = '{2, 32'h8000_0020,
                    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0,
                    1, 1'b0, 256'h0, 32'h8000_0020, 5,
                    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0};
        vecs[2] = '{1, 32'h0000_2FFF, 256'h0, 3, 1'b0,
                    256'hDEADBEEF00000004_DEADBEEF00000003_DEADBEEF00000002_DEADBEEF00000001,
                    32'h0000_2FE0, 13,
                    256'hDEADBEEF00000004_DEADBEEF00000003_DEADBEEF00000002_DEADBEEF00000001};
        vecs[3] = '{2, 32'h4000_007F,
                    256'hA5A5A5A500000003_5A5A5A5A00000002_C3C3C3C300000001_3C3C3C3C00000000,
                    2, 1'b1, 256'h0, 32'h4000_0060, 9,
                    256'hA5A5A5A500000003_5A5A5A5A00000002_C3C3C3C300000001_3C3C3C3C00000000};
        vecs[4] = '{0, 32'hFFFF_FFFF, 256'h0, 1, 1'b0,
                    256'hCAFE000000000003_CAFE000000000002_CAFE000000000001_CAFE000000000000,
                    32'hFFFF_FFE0, 5,
                    256'hCAFE000000000003_CAFE000000000002_CAFE000000000001_CAFE000000000000};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cmds", LW'({i_resp, d_resp, pmem_read, pmem_write}), LW'(4'b0000));
        chk("rst_pmem_addr", LW'(pmem_addr), LW'(32'h0));
        chk("rst_pmem_wdata", LW'(pmem_wdata), LW'(64'h0));
        chk("rst_rdata", i_rdata | d_rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) apply($sformatf("vec%0d", k), vecs[k]);

        // contention: both held, D dropped after the third grant
`ifdef CACHE_ARB_RR_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 0};
`endif
        gap = 1;
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 0; who = -1;
            while (who < 0 && w < 100) begin
                @(negedge clk);
                w++;
                if (i_resp) who = 0;
                else if (d_resp) who = 1;
            end
            chk($sformatf("contention_grant%0d", k), LW'(who), LW'(exp_order[k]));
            if (k == 2) d_read = 1'b0;
            if (k == 3) i_read = 1'b0;
        end
        @(negedge clk);

        // reset during beat 2 of a D read
        for (int b = 0; b < 4; b++) rd_beats[b] = 64'h7700_0000_0000_0000 | 64'(b + 1);
        gap = 1; d_addr = 32'h0000_3000; d_read = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_cmds", LW'({d_resp, pmem_read, pmem_write}), LW'(3'b000));
        chk("midrst_pmem_addr", LW'(pmem_addr), LW'(32'h0));
        chk("midrst_rdata", d_rdata, '0);
        d_read = 1'b0;
        resp_seen = 1'b0;
        repeat (2) @(negedge clk) if (i_resp || d_resp) resp_seen = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk) if (i_resp || d_resp) resp_seen = 1'b1;
        chk("midrst_no_resp", LW'(resp_seen), LW'(1'b0));
        r = '{0, 32'h0000_5008, 256'h0, 1, 1'b0,
              256'h0000000055550003_0000000055550002_0000000055550001_0000000055550000,
              32'h0000_5000, 5,
              256'h0000000055550003_0000000055550002_0000000055550001_0000000055550000};
        apply("post_rst_iread", r);

        // random transactions against the line/latency model
        for (int n = 0; n < 30; n++) begin
            r.kind    = $urandom_range(0, 2);
            r.addr    = $urandom;
            r.gap     = $urandom_range(1, 3);
            r.perturb = 1'b0;
            for (int j = 0; j < 8; j++) begin
                r.wdata[j*32 +: 32] = $urandom;
                r.beats[j*32 +: 32] = $urandom;
            end
            r.exp_addr = r.addr - (r.addr % 32);
            r.exp_lat  = 4 * r.gap + 1;
            r.exp_line = (r.kind == 2) ? r.wdata : r.beats;
            apply($sformatf("rand%0d", n), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
